// File: rtl/vga_rect_engine.sv
// vga_rect_engine
//   Pixel-plotting engine for the simulator VGA pixel interface. It draws one
//   pixel per clock for three operations: a filled rectangle, a rectangle
//   outline and a full-screen clear. All drawing is clipped to XMAX x YMAX.
//
//   State table
//     state | meaning
//     IDLE  | waiting for start; operands are latched when start is seen
//     SETUP | one cycle: compute clipped extents, pixel count, degenerate test
//     DRAW  | one raster pixel per cycle, x fastest, then y
//     DONE  | one cycle: done pulse, busy still high
//
//   Ports
//     CLOCK_50   system clock, all logic on the rising edge
//     reset      synchronous, active-high reset
//     start      request; sampled only in IDLE
//     mode       00 fill, 01 outline, 10 clear screen, 11 fill
//     x0, y0     rectangle top-left corner
//     w, h       rectangle size in pixels
//     color      pixel colour
//     VGA_X/VGA_Y/VGA_COLOR  registered pixel position and colour
//     plot       registered write-enable for the current pixel
//     busy       high from the cycle after start is accepted through DONE
//     done       one-cycle completion pulse
module vga_rect_engine #(
  parameter int XW      = 9,
  parameter int YW      = 8,
  parameter int COLOR_W = 24,
  parameter int XMAX    = 320,
  parameter int YMAX    = 240
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [XW-1:0]      x0,
  input  logic [YW-1:0]      y0,
  input  logic [XW-1:0]      w,
  input  logic [YW-1:0]      h,
  input  logic [COLOR_W-1:0] color,
  output logic [XW-1:0]      VGA_X,
  output logic [YW-1:0]      VGA_Y,
  output logic [COLOR_W-1:0] VGA_COLOR,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam int PCW = $clog2(XMAX * YMAX + 1);
  localparam int NW  = XW + YW + 2;

  localparam logic [XW:0]   XMAX_E = (XW + 1)'(XMAX);
  localparam logic [YW:0]   YMAX_E = (YW + 1)'(YMAX);
  localparam logic [XW:0]   XLAST  = (XW + 1)'(XMAX - 1);
  localparam logic [YW:0]   YLAST  = (YW + 1)'(YMAX - 1);
  localparam logic [XW:0]   ONE_X  = (XW + 1)'(1);
  localparam logic [YW:0]   ONE_Y  = (YW + 1)'(1);
  localparam logic [NW-1:0] ONE_N  = NW'(1);
  localparam logic [PCW-1:0] ONE_P = PCW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  // operands latched on acceptance
  logic               is_clear_q;
  logic               is_outline_q;
  logic [XW-1:0]      x0_q;
  logic [YW-1:0]      y0_q;
  logic [XW-1:0]      w_q;
  logic [YW-1:0]      h_q;
  logic [COLOR_W-1:0] color_q;

  // draw-time geometry computed in SETUP
  logic [XW-1:0]  xs_q;    // first column of each row (clipped region left)
  logic [XW-1:0]  xe_q;    // last column (clipped)
  logic [XW:0]    xr_q;    // unclipped right edge, outline test only
  logic [YW:0]    yb_q;    // unclipped bottom edge, outline test only
  logic [XW-1:0]  cx;
  logic [YW-1:0]  cy;
  logic [PCW-1:0] pix_left; // pixels remaining after the current one

  // SETUP arithmetic, one bit wider than the coordinates so nothing wraps
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  logic [XW:0]   xr_raw, xe_raw, span_x;
  logic [YW:0]   yb_raw, ye_raw, span_y;
  logic [NW-1:0] npix, npix_m1;
  logic          degen;
  logic          on_edge;
  logic          last_px;

  always_comb begin
    sx      = is_clear_q ? '0 : x0_q;
    sy      = is_clear_q ? '0 : y0_q;
    xr_raw  = is_clear_q ? XLAST : ({1'b0, x0_q} + {1'b0, w_q} - ONE_X);
    yb_raw  = is_clear_q ? YLAST : ({1'b0, y0_q} + {1'b0, h_q} - ONE_Y);
    xe_raw  = (xr_raw > XLAST) ? XLAST : xr_raw;
    ye_raw  = (yb_raw > YLAST) ? YLAST : yb_raw;
    span_x  = xe_raw - {1'b0, sx} + ONE_X;
    span_y  = ye_raw - {1'b0, sy} + ONE_Y;
    npix    = NW'(span_x) * NW'(span_y);
    npix_m1 = npix - ONE_N;
    degen   = !is_clear_q &&
              ((w_q == '0) || (h_q == '0) ||
               ({1'b0, x0_q} >= XMAX_E) || ({1'b0, y0_q} >= YMAX_E));
  end

  // Outline edges use the unclipped rectangle so a clipped-away right or
  // bottom edge never shows up on the screen border.
  always_comb begin
    on_edge = (cx == x0_q) || (cy == y0_q) ||
              ({1'b0, cx} == xr_q) || ({1'b0, cy} == yb_q);
    last_px = (pix_left == '0);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   state_nx = degen ? DONE : DRAW;
      DRAW:    if (last_px) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      is_clear_q   <= 1'b0;
      is_outline_q <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      color_q      <= '0;
      xs_q         <= '0;
      xe_q         <= '0;
      xr_q         <= '0;
      yb_q         <= '0;
      cx           <= '0;
      cy           <= '0;
      pix_left     <= '0;
      VGA_X        <= '0;
      VGA_Y        <= '0;
      VGA_COLOR    <= '0;
      plot         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      // busy follows the state one edge late, and rises on acceptance
      busy <= (state == IDLE) ? start : 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            is_clear_q   <= (mode == 2'b10);
            is_outline_q <= (mode == 2'b01);
            x0_q         <= x0;
            y0_q         <= y0;
            w_q          <= w;
            h_q          <= h;
            color_q      <= color;
          end
        end

        SETUP: begin
          xs_q     <= sx;
          xe_q     <= xe_raw[XW-1:0];
          xr_q     <= xr_raw;
          yb_q     <= yb_raw;
          cx       <= sx;
          cy       <= sy;
          pix_left <= npix_m1[PCW-1:0];
        end

        DRAW: begin
          VGA_X     <= cx;
          VGA_Y     <= cy;
          VGA_COLOR <= color_q;
          plot      <= !is_outline_q || on_edge;
          pix_left  <= pix_left - ONE_P;
          if (cx < xe_q) begin
            cx <= cx + 1'b1;
          end else begin
            cx <= xs_q;
            cy <= cy + 1'b1;
          end
        end

        DONE: done <= 1'b1;

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_engine.sv
module tb_vga_rect_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 320x240 instance
  logic        a_start;
  logic [1:0]  a_mode;
  logic [8:0]  a_x0, a_w;
  logic [7:0]  a_y0, a_h;
  logic [23:0] a_color;
  logic [8:0]  a_vx;
  logic [7:0]  a_vy;
  logic [23:0] a_vc;
  logic        a_plot, a_busy, a_done;

  // 160x120 instance
  logic        b_start;
  logic [1:0]  b_mode;
  logic [7:0]  b_x0, b_w;
  logic [6:0]  b_y0, b_h;
  logic [23:0] b_color;
  logic [7:0]  b_vx;
  logic [6:0]  b_vy;
  logic [23:0] b_vc;
  logic        b_plot, b_busy, b_done;

  vga_rect_engine u_a (
    .CLOCK_50(clk), .reset(reset), .start(a_start), .mode(a_mode),
    .x0(a_x0), .y0(a_y0), .w(a_w), .h(a_h), .color(a_color),
    .VGA_X(a_vx), .VGA_Y(a_vy), .VGA_COLOR(a_vc),
    .plot(a_plot), .busy(a_busy), .done(a_done)
  );

  vga_rect_engine #(.XW(8), .YW(7), .COLOR_W(24), .XMAX(160), .YMAX(120)) u_b (
    .CLOCK_50(clk), .reset(reset), .start(b_start), .mode(b_mode),
    .x0(b_x0), .y0(b_y0), .w(b_w), .h(b_h), .color(b_color),
    .VGA_X(b_vx), .VGA_Y(b_vy), .VGA_COLOR(b_vc),
    .plot(b_plot), .busy(b_busy), .done(b_done)
  );

  int n_pass  = 0;
  int n_total = 0;

  // expected DRAW-cycle stream for the 320x240 instance
  int exp_x[$];
  int exp_y[$];
  bit exp_p[$];

  // Reference: enumerate the clipped region in raster order; outline pixels
  // are the ones on any unclipped edge of the requested rectangle.
  task automatic build_model(input int x0, input int y0, input int w,
                             input int h, input int mode);
    int xs, ys, xe, ye;
    bit outl;
    exp_x.delete();
    exp_y.delete();
    exp_p.delete();
    outl = (mode == 1);
    if (mode == 2) begin
      xs = 0; ys = 0; xe = 319; ye = 239;
    end else begin
      if (w == 0 || h == 0 || x0 >= 320 || y0 >= 240) return;
      xs = x0; ys = y0;
      xe = (x0 + w - 1 > 319) ? 319 : x0 + w - 1;
      ye = (y0 + h - 1 > 239) ? 239 : y0 + h - 1;
    end
    for (int y = ys; y <= ye; y++)
      for (int x = xs; x <= xe; x++) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
        exp_p.push_back(!outl || x == x0 || y == y0 || x == x0 + w - 1 || y == y0 + h - 1);
      end
  endtask

  task automatic run_op(input string tag, input int x0, input int y0, input int w,
                        input int h, input int mode, input int col, input bit disturb);
    int n;
    build_model(x0, y0, w, h, mode);
    n = exp_x.size();
    @(negedge clk);
    a_x0 = 9'(x0); a_y0 = 8'(y0); a_w = 9'(w); a_h = 8'(h);
    a_mode = 2'(mode); a_color = 24'(col); a_start = 1'b1;
    @(posedge clk); #1;                       // edge k
    a_start = 1'b0;
    n_total++;
    if (a_busy !== 1'b1 || a_plot !== 1'b0) $display("FAIL %s setup busy/plot got %b/%b exp 1/0", tag, a_busy, a_plot);
    else n_pass++;
    @(posedge clk); #1;                       // edge k+1
    n_total++;
    if (a_plot !== 1'b0 || a_done !== 1'b0) $display("FAIL %s pre_draw plot/done got %b/%b exp 0/0", tag, a_plot, a_done);
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      if (disturb) begin
        a_start = 1'b1;
        a_x0    = 9'($urandom_range(0, 319));
        a_w     = 9'($urandom_range(0, 20));
        a_color = 24'($urandom);
      end
      @(posedge clk); #1;                     // edge k+2+i
      n_total++;
      if (a_plot !== exp_p[i]) $display("FAIL %s plot[%0d] got %b exp %b", tag, i, a_plot, exp_p[i]);
      else n_pass++;
      n_total++;
      if (int'(a_vx) != exp_x[i] || int'(a_vy) != exp_y[i])
        $display("FAIL %s xy[%0d] got (%0d,%0d) exp (%0d,%0d)", tag, i, a_vx, a_vy, exp_x[i], exp_y[i]);
      else n_pass++;
      n_total++;
      if (a_vc !== 24'(col) || a_done !== 1'b0 || a_busy !== 1'b1)
        $display("FAIL %s color/done/busy[%0d] got %h/%b/%b exp %h/0/1", tag, i, a_vc, a_done, a_busy, 24'(col));
      else n_pass++;
    end
    @(posedge clk); #1;                       // edge k+2+N
    a_start = 1'b0;
    n_total++;
    if (a_done !== 1'b1 || a_plot !== 1'b0 || a_busy !== 1'b1)
      $display("FAIL %s done_pulse done/plot/busy got %b/%b/%b exp 1/0/1", tag, a_done, a_plot, a_busy);
    else n_pass++;
    @(posedge clk); #1;                       // edge k+3+N
    n_total++;
    if (a_done !== 1'b0 || a_busy !== 1'b0 || a_plot !== 1'b0)
      $display("FAIL %s idle done/busy/plot got %b/%b/%b exp 0/0/0", tag, a_done, a_busy, a_plot);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_start = 0; a_mode = 0; a_x0 = 0; a_y0 = 0; a_w = 0; a_h = 0; a_color = 0;
    b_start = 0; b_mode = 0; b_x0 = 0; b_y0 = 0; b_w = 0; b_h = 0; b_color = 0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({a_vx, a_vy, a_vc, a_plot, a_busy, a_done} !== '0)
      $display("FAIL reset_a got x=%0d y=%0d c=%h p=%b b=%b d=%b exp all 0", a_vx, a_vy, a_vc, a_plot, a_busy, a_done);
    else n_pass++;
    n_total++;
    if ({b_vx, b_vy, b_vc, b_plot, b_busy, b_done} !== '0)
      $display("FAIL reset_b got x=%0d y=%0d c=%h p=%b b=%b d=%b exp all 0", b_vx, b_vy, b_vc, b_plot, b_busy, b_done);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_fill();
    run_op("fill", 10, 20, 3, 2, 0, 24'hFF0000, 1'b0);
    run_op("fill_mode3", 100, 50, 4, 3, 3, 24'h123456, 1'b0);
  endtask

  task automatic test_outline();
    run_op("outline", 0, 0, 4, 3, 1, 24'h0000FF, 1'b0);
    run_op("outline_big", 30, 40, 6, 5, 1, 24'hABCDEF, 1'b0);
  endtask

  task automatic test_clip();
    run_op("clip_fill", 318, 239, 5, 3, 0, 24'h00FFFF, 1'b0);
    run_op("clip_outline", 318, 239, 5, 3, 1, 24'hFF00FF, 1'b0);
    run_op("clip_right", 315, 100, 9, 2, 1, 24'h777777, 1'b0);
  endtask

  task automatic test_degenerate();
    run_op("degen_w0", 10, 10, 0, 5, 0, 24'h111111, 1'b0);
    run_op("degen_h0", 10, 10, 5, 0, 1, 24'h222222, 1'b0);
    run_op("degen_x320", 320, 10, 5, 5, 0, 24'h333333, 1'b0);
    run_op("degen_y240", 10, 240, 5, 5, 0, 24'h444444, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op("disturb_fill", 60, 70, 5, 3, 0, 24'h5A5A5A, 1'b1);
    run_op("disturb_outline", 200, 100, 4, 4, 1, 24'hA5A5A5, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_x0 = 9'd50; a_y0 = 8'd60; a_w = 9'd8; a_h = 8'd2; a_mode = 2'd0;
    a_color = 24'hC0FFEE; a_start = 1'b1;
    @(posedge clk); #1;                       // edge k
    a_start = 1'b0;
    repeat (4) @(posedge clk);                // edges k+1..k+4
    #1;
    n_total++;
    if (a_plot !== 1'b1 || a_vx !== 9'd52 || a_vy !== 8'd60)
      $display("FAIL rst_mid third_pixel got p=%b (%0d,%0d) exp p=1 (52,60)", a_plot, a_vx, a_vy);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_total++;
    if ({a_vx, a_vy, a_vc, a_plot, a_busy, a_done} !== '0)
      $display("FAIL rst_mid cleared got x=%0d y=%0d c=%h p=%b b=%b d=%b exp all 0", a_vx, a_vy, a_vc, a_plot, a_busy, a_done);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (a_plot !== 1'b0 || a_busy !== 1'b0)
      $display("FAIL rst_mid stays_idle got p=%b b=%b exp 0/0", a_plot, a_busy);
    else n_pass++;
    run_op("after_reset", 50, 60, 3, 2, 0, 24'hBEEF00, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int m, x0, y0, w, h;
      m  = $urandom_range(0, 2);
      if (m == 2) m = 3;
      x0 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 319) : $urandom_range(305, 330);
      y0 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 239) : $urandom_range(228, 250);
      w  = $urandom_range(0, 10);
      h  = $urandom_range(0, 8);
      run_op($sformatf("rand%0d", t), x0, y0, w, h, m, int'($urandom & 32'h00FF_FFFF),
             1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_clear();
    int nplot, bad, done_at, first_bad;
    nplot = 0; bad = 0; done_at = -1; first_bad = -1;
    @(negedge clk);
    b_mode = 2'b10; b_color = 24'h00FF00;
    b_x0 = 8'd77; b_y0 = 7'd33; b_w = 8'd0; b_h = 7'd0;   // ignored in clear
    b_start = 1'b1;
    @(posedge clk); #1;                       // edge k
    b_start = 1'b0;
    for (int c = 1; c <= 19204; c++) begin
      @(posedge clk); #1;
      if (b_done && done_at < 0) done_at = c;
      if (b_plot) begin
        if (c != nplot + 2 || int'(b_vx) != nplot % 160 || int'(b_vy) != nplot / 160 || b_vc !== 24'h00FF00) begin
          bad++;
          if (first_bad < 0) first_bad = nplot;
        end
        nplot++;
      end
    end
    n_total++;
    if (nplot != 19200) $display("FAIL clear plot_count got %0d exp 19200", nplot);
    else n_pass++;
    n_total++;
    if (bad != 0) $display("FAIL clear stream got %0d bad pixels (first at %0d) exp 0", bad, first_bad);
    else n_pass++;
    n_total++;
    if (done_at != 19202) $display("FAIL clear done_edge got %0d exp 19202", done_at);
    else n_pass++;
    n_total++;
    if (b_busy !== 1'b0 || a_busy !== 1'b0) $display("FAIL clear end_busy got b=%b a=%b exp 0/0", b_busy, a_busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_outline();
    test_clip();
    test_degenerate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
